// File: rtl/rv32i_instr_encoder_if.sv
// ---------------------------------------------------------------------------
// rv32i_instr_encoder_if
// Field-beat input channel and encoded-word output channel of the RV32I
// instruction encoder.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A source holds valid and its payload stable until that edge.
// ready may depend on the sink's own state but never on valid.
//
// Modports:
//   master : producer of field beats and consumer of encoded words (bench, boot code)
//   slave  : the encoder itself
// Signals:
//   in_valid/in_ready, in_fmt, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
//   in_imm, in_last                 field beat channel
//   out_valid/out_ready, out_instr, out_addr, out_last   encoded word channel
// ---------------------------------------------------------------------------
interface rv32i_instr_encoder_if #(
    parameter int ADDR_W = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output in_valid, in_fmt, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
               in_imm, in_last, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_last
    );

    modport slave (
        input  in_valid, in_fmt, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
               in_imm, in_last, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_last
    );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv32i_instr_encoder
// Streaming RV32I instruction encoder / program loader. Decoded fields arrive
// as beats on bus.in_*; each legal beat is packed into a 32-bit R/I/S/B/J word
// and presented on bus.out_* one cycle later together with an auto-
// incrementing word address, ready to be written into instruction memory.
//
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   start       single-cycle pulse, restarts loading when in DONE
//   bus         rv32i_instr_encoder_if.slave (field beats in, words out)
//   done        high while the FSM is in DONE
//   err         sticky: reserved fmt, misaligned B/J immediate, address wrap
//   count       output handshakes since reset/start, saturating
//   fsm_state   current FSM state (0 LOAD, 1 DRAIN, 2 DONE)
// ---------------------------------------------------------------------------
module rv32i_instr_encoder #(
    parameter int                ADDR_W    = 9,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    rv32i_instr_encoder_if.slave bus,
    output logic               done,
    output logic               err,
    output logic [ADDR_W:0]    count,
    output logic [1:0]         fsm_state
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] FMT_R      = 3'd0;
    localparam logic [2:0] FMT_I_ALU  = 3'd1;
    localparam logic [2:0] FMT_LOAD   = 3'd2;
    localparam logic [2:0] FMT_STORE  = 3'd3;
    localparam logic [2:0] FMT_BRANCH = 3'd4;
    localparam logic [2:0] FMT_JAL    = 3'd5;
    localparam logic [2:0] FMT_JALR   = 3'd6;
    localparam logic [2:0] FMT_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              out_last_q;
    logic [ADDR_W-1:0] next_addr;   // address the next emitted word will take

    logic [31:0]       enc_word;
    logic              accept;
    logic              out_fire;
    logic              bad_fmt;
    logic              misaligned;

    assign fsm_state     = state;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;

    // A beat may enter whenever the single output register is empty or is
    // being drained in the same cycle, giving full throughput.
    assign bus.in_ready = (state == S_LOAD) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_fire     = out_valid_q && bus.out_ready;

    assign bad_fmt    = (bus.in_fmt == FMT_RSVD);
    assign misaligned = ((bus.in_fmt == FMT_BRANCH) || (bus.in_fmt == FMT_JAL))
                        && bus.in_imm[0];

    // Immediate bits above bit 20 never reach any format.
    logic unused_imm;
    assign unused_imm = &{1'b0, bus.in_imm[31:21]};

    always_comb begin
        enc_word = '0;
        case (bus.in_fmt)
            FMT_R: begin
                enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_rd, OP_R};
            end
            FMT_I_ALU: begin
                // Shifts carry funct7 in the upper bits and a 5-bit shamt.
                if ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101)) begin
                    enc_word = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1,
                                bus.in_funct3, bus.in_rd, OP_I_ALU};
                end else begin
                    enc_word = {bus.in_imm[11:0], bus.in_rs1,
                                bus.in_funct3, bus.in_rd, OP_I_ALU};
                end
            end
            FMT_LOAD: begin
                enc_word = {bus.in_imm[11:0], bus.in_rs1,
                            bus.in_funct3, bus.in_rd, OP_LOAD};
            end
            FMT_STORE: begin
                enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_imm[4:0], OP_STORE};
            end
            FMT_BRANCH: begin
                enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2,
                            bus.in_rs1, bus.in_funct3, bus.in_imm[4:1],
                            bus.in_imm[11], OP_BRANCH};
            end
            FMT_JAL: begin
                enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                            bus.in_imm[19:12], bus.in_rd, OP_JAL};
            end
            FMT_JALR: begin
                enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b000,
                            bus.in_rd, OP_JALR};
            end
            default: enc_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_LOAD;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            out_last_q  <= 1'b0;
            next_addr   <= BASE_ADDR;
            done        <= 1'b0;
            err         <= 1'b0;
            count       <= '0;
        end else begin
            if (out_fire) begin
                out_valid_q <= 1'b0;
                if (count != '1) begin
                    count <= count + 1'b1;
                end
            end

            if (accept) begin
                if (bad_fmt) begin
                    // Beat consumed and dropped; address does not advance.
                    err <= 1'b1;
                end else begin
                    out_valid_q <= 1'b1;
                    out_instr_q <= enc_word;
                    out_addr_q  <= next_addr;
                    out_last_q  <= bus.in_last;
                    next_addr   <= next_addr + 1'b1;
                    if ((next_addr == '1) || misaligned) begin
                        err <= 1'b1;
                    end
                end
            end

            case (state)
                S_LOAD: begin
                    if (accept && bus.in_last) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // No new beats can enter here, so whatever is held is the
                    // final word; leave once it is gone or leaving this cycle.
                    if (!out_valid_q || bus.out_ready) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        count      <= '0;
                        next_addr  <= BASE_ADDR;
                        out_addr_q <= BASE_ADDR;
                    end
                end
                default: begin
                    state <= S_LOAD;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/rv32i_instr_encoder.md
# rv32i_instr_encoder

Streaming RV32I instruction encoder and program loader, the encode-side counterpart of the main opcode decoder. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit R/I/S/B/J instruction words with the correct opcode. Each word is emitted with an auto-incrementing word address, so the stream can be written straight into instruction memory. Bench and boot code use it to build programs that the core's decoder then consumes.

## Interface
- ADDR_W, 9: width of emitted word address.
- BASE_ADDR, 0: first word address after reset or `start`.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; restarts loading from DONE
- in_valid  in  1  field beat valid
- in_ready  out  1  encoder can accept a beat
- in_fmt  in  3  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 reserved
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (R type; I-ALU shifts only)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  sign-extended immediate, in byte units for B/J
- in_last  in  1  final beat of program
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_instr
- out_last  out  1  out_instr is the program's final word
- done  out  1  high in DONE state
- err  out  1  sticky error flag
- count  out  ADDR_W+1  words emitted since reset/start

## Operation
- Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111.
- R: {funct7, rs2, rs1, funct3, rd, op}.
- I-ALU/LOAD: {imm[11:0], rs1, funct3, rd, op}.
  - I-ALU with funct3 001/101 instead uses {funct7, imm[4:0], rs1, funct3, rd, op}.
- JALR: I layout with funct3 forced to 000.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Ignored fields: immediate bits above the format width are dropped without checking. Unused register fields are ignored.
- err is set (sticky) by any of:
  - fmt 7: beat is consumed but dropped; no word emitted, address not advanced. If the beat also carries in_last, the FSM still goes to DRAIN/DONE.
  - B/J beat with imm[0]=1: word is still emitted with bit 0 discarded.
  - Address wrap from all-ones to 0.
- FSM states: LOAD, DRAIN, DONE.
  - LOAD: accepts beats. On an accepted beat with in_last=1, go to DRAIN.
  - DRAIN: in_ready=0. When the output register is empty, or its last word handshakes, go to DONE.
  - DONE: done=1, in_ready=0. start → LOAD, with address set to BASE_ADDR, count=0 and err cleared.
- start outside DONE has no effect.

## Timing
- One output register stage. Latency is 1 cycle from input handshake to out_valid.
- in_ready = (state==LOAD) && (!out_valid || out_ready). Back-to-back beats therefore sustain 1 word/cycle with no bubbles.
- Hold rule: out_instr, out_addr and out_last stay stable while out_valid && !out_ready.
- out_addr increments after each emitted word and wraps modulo 2^ADDR_W.
- count increments on each output handshake and saturates at all-ones.
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_last=0, done=0, err=0, count=0, state=LOAD. in_ready is 1 in the first cycle after reset.
- Reset mid-stream discards any pending word. No output handshake occurs in the reset cycle.
- If reset and start are asserted together, reset wins.

## Test plan
- addi x1,x0,5 (fmt1, f3 0, imm 5): out_instr=0x00500093, out_addr=0. Then add x3,x1,x2 (fmt0, f7 0): 0x002081B3 at addr 1.
- srai x5,x5,3 (fmt1, f3 101, f7 0100000): 0x4032D293. sw x2,8(x1) (fmt3, f3 010): 0x0020A423.
- beq x1,x2,imm=0xFFFFFFF8: 0xFE208CE3. jal x1,16 with in_last=1: 0x010000EF with out_last=1. done rises the cycle after that handshake.
- Hold out_ready=0 for 5 cycles with 3 beats offered: only 1 beat is accepted and out_instr is stable. Then release: 3 words at consecutive addresses, no bubbles.
- fmt 7 beat followed by a valid beat: err=1, and the valid word takes the address the dropped beat would have used. A start pulse in DONE clears err, count and address.
- Assert reset while out_valid=1 and out_ready=0: next cycle out_valid=0, out_addr=BASE_ADDR, count=0.
